// File: rtl/alu_pkg.sv
// Shared types and constants for the two-bit-sliced ALU sequencer and its benches.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } seq_state_t;

  // 74181 selects used by the benches (active-high data)
  localparam logic [3:0] S_XOR = 4'b0110;
  localparam logic       M_XOR = 1'b1;
  localparam logic [3:0] S_ADD = 4'b1001;
  localparam logic       M_ADD = 1'b0;

  function automatic int idx_width(input int slices);
    return (slices > 1) ? $clog2(slices) : 1;
  endfunction

endpackage

// File: rtl/alu2bit_seq_if.sv
// Request/response handshake bundle between a requester and alu2bit_seq.
interface alu2bit_seq_if #(
  parameter int WIDTH = 8
);

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [3:0]       req_s;
  logic             req_m;
  logic             req_cin;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_f;
  logic             rsp_cout;
  logic             rsp_zero;

  modport master (
    output req_valid, req_a, req_b, req_s, req_m, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_f, rsp_cout, rsp_zero
  );

  modport slave (
    input  req_valid, req_a, req_b, req_s, req_m, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_f, rsp_cout, rsp_zero
  );

endinterface

// File: rtl/alu2bit.sv
// Two-bit 74181-style ALU slice, purely combinational; cin/cout are active-low.
module alu2bit (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       cin,
  output logic [1:0] f,
  output logic       cout
);

  logic [1:0] t_or;
  logic [1:0] t_and;
  logic [1:0] p;
  logic       c0;
  logic       c1;
  logic       c2;

  // Arithmetic result is t_or + t_and + carry; t_and is a subset of t_or so
  // t_and is the generate term and t_or ^ t_and the propagate term.
  always_comb begin
    t_or  = a | ({2{s[0]}} & b) | ({2{s[1]}} & ~b);
    t_and = ({2{s[2]}} & a & ~b) | ({2{s[3]}} & a & b);
    p     = t_or ^ t_and;
    c0    = ~cin;
    c1    = t_and[0] | (p[0] & c0);
    c2    = t_and[1] | (p[1] & c1);
    f     = m ? ~p : (p ^ {c1, c0});
    cout  = ~c2;
  end

endmodule

// File: rtl/alu2bit_seq.sv
// Runs WIDTH-bit ALU operations LSB-first through one alu2bit slice, two bits
// per clock, chaining the slice carry through a register between cycles.
module alu2bit_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  alu2bit_seq_if.slave  bus
);

  localparam int SLICES = WIDTH / 2;
  localparam int IDX_W  = idx_width(SLICES);

  seq_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       s_q, s_d;
  logic             m_q, m_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] rsp_f_q, rsp_f_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic             rsp_zero_q, rsp_zero_d;

  logic [1:0]       slice_f;
  logic             slice_cout;
  logic [WIDTH+1:0] res_shift;

  alu2bit u_slice (
    .a    (a_q[1:0]),
    .b    (b_q[1:0]),
    .s    (s_q),
    .m    (m_q),
    .cin  (carry_q),
    .f    (slice_f),
    .cout (slice_cout)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    s_d        = s_q;
    m_d        = m_q;
    carry_d    = carry_q;
    idx_d      = idx_q;
    rsp_f_d    = rsp_f_q;
    rsp_cout_d = rsp_cout_q;
    rsp_zero_d = rsp_zero_q;
    // New slice bits enter at the top so the result ends LSB-aligned after SLICES steps
    res_shift  = {slice_f, res_q};

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          a_d     = bus.req_a;
          b_d     = bus.req_b;
          s_d     = bus.req_s;
          m_d     = bus.req_m;
          carry_d = bus.req_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = res_shift[WIDTH+1:2];
        carry_d = slice_cout;
        a_d     = a_q >> 2;
        b_d     = b_q >> 2;
        if (idx_q == IDX_W'(SLICES - 1)) begin
          rsp_f_d    = res_shift[WIDTH+1:2];
          rsp_cout_d = slice_cout;
          rsp_zero_d = (res_shift[WIDTH+1:2] == '0);
          state_d    = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      s_q        <= '0;
      m_q        <= 1'b0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
      rsp_f_q    <= '0;
      rsp_cout_q <= 1'b1;
      rsp_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      s_q        <= s_d;
      m_q        <= m_d;
      carry_q    <= carry_d;
      idx_q      <= idx_d;
      rsp_f_q    <= rsp_f_d;
      rsp_cout_q <= rsp_cout_d;
      rsp_zero_q <= rsp_zero_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_f     = rsp_f_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_alu2bit_seq.sv
// Self-checking bench for alu2bit_seq: vector table through a scoreboard queue,
// plus backpressure, operand-change and mid-operation reset sequences.
module tb_alu2bit_seq;
  import alu_pkg::*;

  localparam int WIDTH  = 8;
  localparam int SLICES = WIDTH / 2;
  localparam int NV     = 14;
  localparam int BOUND  = 4 * SLICES + 8;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] s;
    logic       m;
    logic       cin;
    logic [7:0] f;
    logic       cout;
    logic       zero;
  } vec_t;

  typedef struct {
    logic [7:0] f;
    logic       cout;
    logic       zero;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  alu2bit_seq_if #(.WIDTH(WIDTH)) bus ();

  alu2bit_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  exp_t        exp_q[$];
  vec_t        tbl[NV];

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                              input logic m, input logic cin, input logic [7:0] f,
                              input logic cout, input logic zero);
    vec_t v;
    v.a = a; v.b = b; v.s = s; v.m = m; v.cin = cin;
    v.f = f; v.cout = cout; v.zero = zero;
    return v;
  endfunction

  // Reference: 74181 function tables written out per select code
  function automatic vec_t ref_vec(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                                   input logic m, input logic cin);
    vec_t       v;
    logic [8:0] sum;
    logic [8:0] c9;
    logic [8:0] a9;
    logic [8:0] nb9;
    logic [8:0] b9;
    logic [7:0] lf;
    c9  = {8'd0, ~cin};
    a9  = {1'b0, a};
    b9  = {1'b0, b};
    nb9 = {1'b0, ~b};
    case (s)
      4'h0: sum = a9 + c9;
      4'h1: sum = (a9 | b9) + c9;
      4'h2: sum = (a9 | nb9) + c9;
      4'h3: sum = 9'h0FF + c9;
      4'h4: sum = a9 + (a9 & nb9) + c9;
      4'h5: sum = (a9 | b9) + (a9 & nb9) + c9;
      4'h6: sum = a9 + nb9 + c9;
      4'h7: sum = (a9 & nb9) + 9'h0FF + c9;
      4'h8: sum = a9 + (a9 & b9) + c9;
      4'h9: sum = a9 + b9 + c9;
      4'hA: sum = (a9 | nb9) + (a9 & b9) + c9;
      4'hB: sum = (a9 & b9) + 9'h0FF + c9;
      4'hC: sum = a9 + a9 + c9;
      4'hD: sum = (a9 | b9) + a9 + c9;
      4'hE: sum = (a9 | nb9) + a9 + c9;
      default: sum = a9 + 9'h0FF + c9;
    endcase
    case (s)
      4'h0: lf = ~a;
      4'h1: lf = ~(a | b);
      4'h2: lf = ~a & b;
      4'h3: lf = 8'h00;
      4'h4: lf = ~(a & b);
      4'h5: lf = ~b;
      4'h6: lf = a ^ b;
      4'h7: lf = a & ~b;
      4'h8: lf = ~a | b;
      4'h9: lf = ~(a ^ b);
      4'hA: lf = b;
      4'hB: lf = a & b;
      4'hC: lf = 8'hFF;
      4'hD: lf = a | ~b;
      4'hE: lf = a | b;
      default: lf = a;
    endcase
    v.a = a; v.b = b; v.s = s; v.m = m; v.cin = cin;
    v.f    = m ? lf : sum[7:0];
    v.cout = ~sum[8];
    v.zero = (v.f == 8'h00);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic fail_bound(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound of %0d cycles expired", name, BOUND);
  endtask

  // Drive a request, wait for acceptance, then scramble the request inputs.
  task automatic send(input vec_t v, input bit valid_in_run);
    int unsigned w;
    exp_t        e;
    w = 0;
    bus.req_a     = v.a;
    bus.req_b     = v.b;
    bus.req_s     = v.s;
    bus.req_m     = v.m;
    bus.req_cin   = v.cin;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && w < BOUND) begin
      @(negedge clk);
      w++;
    end
    if (!bus.req_ready) begin
      fail_bound("req_accept");
      bus.req_valid = 1'b0;
      return;
    end
    e.f = v.f; e.cout = v.cout; e.zero = v.zero;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus.req_a     = 8'($urandom);
    bus.req_b     = 8'($urandom);
    bus.req_s     = 4'($urandom);
    bus.req_m     = 1'($urandom);
    bus.req_cin   = 1'($urandom);
    bus.req_valid = valid_in_run ? 1'($urandom) : 1'b0;
  endtask

  // Called on the negedge after the accept edge; lat counts edges to rsp_valid.
  task automatic collect(output int unsigned lat);
    exp_t e;
    bit   ready_seen;
    lat        = 0;
    ready_seen = 1'b0;
    while (!bus.rsp_valid && lat < BOUND) begin
      if (bus.req_ready) ready_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    bus.req_valid = 1'b0;
    check("busy_req_ready", 32'(ready_seen), 32'd0);
    if (!bus.rsp_valid) begin
      fail_bound("rsp_valid");
      return;
    end
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard: got response, required none pending");
      return;
    end
    e = exp_q.pop_front();
    check("rsp_f", 32'(bus.rsp_f), 32'(e.f));
    check("rsp_cout", 32'(bus.rsp_cout), 32'(e.cout));
    check("rsp_zero", 32'(bus.rsp_zero), 32'(e.zero));
  endtask

  initial begin
    int unsigned lat;
    bit          pulse_seen;

    tbl[0]  = mk(8'h5A, 8'h3C, S_XOR, M_XOR, 1'b1, 8'h66, 1'b0, 1'b0);
    tbl[1]  = mk(8'h0F, 8'h01, S_ADD, M_ADD, 1'b1, 8'h10, 1'b1, 1'b0);
    tbl[2]  = mk(8'hFF, 8'h01, S_ADD, M_ADD, 1'b1, 8'h00, 1'b0, 1'b1);
    tbl[3]  = mk(8'h7F, 8'h80, S_ADD, M_ADD, 1'b0, 8'h00, 1'b0, 1'b1);
    tbl[4]  = mk(8'h20, 8'h05, 4'h6, 1'b0, 1'b1, 8'h1A, 1'b0, 1'b0);
    tbl[5]  = mk(8'h20, 8'h05, 4'h6, 1'b0, 1'b0, 8'h1B, 1'b0, 1'b0);
    tbl[6]  = mk(8'hAB, 8'hCD, 4'h3, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1);
    tbl[7]  = mk(8'h81, 8'h00, 4'hC, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
    tbl[8]  = mk(8'h00, 8'h37, 4'hF, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
    tbl[9]  = mk(8'hF0, 8'h3C, 4'hB, 1'b1, 1'b1, 8'h30, 1'b0, 1'b0);
    tbl[10] = ref_vec(8'($urandom), 8'($urandom), S_ADD, M_ADD, 1'($urandom));
    tbl[11] = ref_vec(8'($urandom), 8'($urandom), S_XOR, M_XOR, 1'b1);
    tbl[12] = ref_vec(8'($urandom), 8'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
    tbl[13] = ref_vec(8'($urandom), 8'($urandom), 4'($urandom), 1'b0, 1'($urandom));

    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_s     = '0;
    bus.req_m     = 1'b0;
    bus.req_cin   = 1'b1;
    bus.rsp_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_state", {bus.req_ready, bus.rsp_valid, bus.rsp_f, bus.rsp_cout, bus.rsp_zero},
          {1'b1, 1'b0, 8'h00, 1'b1, 1'b0});
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back table with rsp_ready held high: DONE lasts exactly one cycle
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      send(tbl[i], 1'b1);
      collect(lat);
      check("latency", 32'(lat), 32'(SLICES));
      @(negedge clk);
      check("done_one_cycle", {bus.rsp_valid, bus.req_ready}, 2'b01);
    end

    // Backpressure with a pending second request held on the bus
    bus.rsp_ready = 1'b0;
    send(tbl[1], 1'b0);
    collect(lat);
    check("bp_latency", 32'(lat), 32'(SLICES));
    bus.req_a     = tbl[7].a;
    bus.req_b     = tbl[7].b;
    bus.req_s     = tbl[7].s;
    bus.req_m     = tbl[7].m;
    bus.req_cin   = tbl[7].cin;
    bus.req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_hold", {bus.rsp_valid, bus.req_ready, bus.rsp_f, bus.rsp_cout},
            {1'b1, 1'b0, tbl[1].f, tbl[1].cout});
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_idle_after_handshake", {bus.rsp_valid, bus.req_ready}, 2'b01);
    send(tbl[7], 1'b0);
    collect(lat);
    check("bp_second_latency", 32'(lat), 32'(SLICES));
    @(negedge clk);

    // Asynchronous reset after two RUN cycles aborts the operation
    send(tbl[0], 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid_run", {bus.req_ready, bus.rsp_valid, bus.rsp_f, bus.rsp_cout, bus.rsp_zero},
          {1'b1, 1'b0, 8'h00, 1'b1, 1'b0});
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulse_seen = 1'b0;
    for (int c = 0; c < SLICES + 3; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) pulse_seen = 1'b1;
    end
    check("no_rsp_after_abort", 32'(pulse_seen), 32'd0);
    send(tbl[4], 1'b0);
    collect(lat);
    check("post_reset_latency", 32'(lat), 32'(SLICES));
    @(negedge clk);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu2bit_seq.md
# alu2bit_seq

Multi-cycle sequencer that runs WIDTH-bit ALU operations through a single shared `alu2bit` slice, two bits per clock. It works LSB-first and chains the slice carry through a register between cycles. It sits between an operation requester and the `alu2bit` datapath, and uses a valid/ready handshake on both sides. One operation is in flight at a time.

## Interface
- `WIDTH`, default 8: operand/result width. Must be even and ≥2. SLICES = WIDTH/2.
- `clk` input, 1 bit: sole clock, rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `req_valid` input, 1 bit: request present.
- `req_ready` output, 1 bit: sequencer can accept; high only in IDLE.
- `req_a` input, WIDTH bits: operand A.
- `req_b` input, WIDTH bits: operand B.
- `req_s` input, 4 bits: function select, passed unchanged to every slice.
- `req_m` input, 1 bit: mode (1 = logic, 0 = arithmetic), passed to every slice.
- `req_cin` input, 1 bit: carry-in to slice 0, active-low per the `alu2bit` convention.
- `rsp_valid` output, 1 bit: result present.
- `rsp_ready` input, 1 bit: consumer accepts the result.
- `rsp_f` output, WIDTH bits: result.
- `rsp_cout` output, 1 bit: carry-out of the last slice, active-low.
- `rsp_zero` output, 1 bit: `rsp_f` == 0.

## Operation
- `alu2bit` encoding is the 74181 active-high table: 4-bit `s`, `m` selects logic/arithmetic, `cin`/`cout` active-low.
- FSM states: IDLE, RUN, DONE.
  - IDLE: `req_ready`=1. On `req_valid` & `req_ready`, capture a, b, s, m into registers, set carry reg = `req_cin`, set slice index = 0, go to RUN.
  - RUN: drive the slice with a_reg[1:0], b_reg[1:0], s_reg, m_reg, carry reg. Each cycle:
    - shift slice f into result reg at bits [WIDTH-1:WIDTH-2], shifting right by 2;
    - load slice cout into carry reg;
    - shift a_reg and b_reg right by 2;
    - increment the index.
  - RUN exit: when index == SLICES-1, go to DONE on that edge. At the same edge, load `rsp_f` from the final result, `rsp_cout` from the slice cout, and `rsp_zero` from the final result.
  - DONE: `rsp_valid`=1. `rsp_f`, `rsp_cout` and `rsp_zero` stay stable until `rsp_valid` & `rsp_ready`, then go to IDLE.
- The carry chains in every mode. In logic mode `alu2bit` ignores carry for f, but `rsp_cout` still reports the last slice cout.
- Request inputs are ignored outside the IDLE accept edge. Changes during RUN/DONE have no effect.
- `req_valid` while busy stalls the requester (`req_ready`=0). Nothing is dropped or queued.
- The slice index is $clog2(SLICES) bits with a minimum of 1. It never wraps inside RUN.
- Reset mid-operation: the operation is aborted and no response is produced. The operation is not resumed after reset.

## Timing
- Reset values: state IDLE, so `req_ready`=1. `rsp_valid`=0, `rsp_f`=0, `rsp_cout`=1 (inactive), `rsp_zero`=0. Carry reg, index, and operand/result regs are all 0.
- `req_ready` and `rsp_valid` are decoded from state only. There is no combinational path from `req_valid` or `rsp_ready`.
- Latency: request accepted at edge E0, `rsp_valid` high after edge E(SLICES). For WIDTH=8 that is 4 cycles.
- Minimum issue interval: SLICES+2 cycles (RUN ×SLICES, DONE ×1 with `rsp_ready` high, IDLE ×1).
- `rsp_ready` may be held high in advance. DONE then lasts exactly 1 cycle.

## Structure
- Shared package `alu_pkg`:
  - state enum: IDLE/RUN/DONE;
  - localparams for the 74181 selects used by the benches: S_XOR = 4'b0110 with m=1, S_ADD = 4'b1001 with m=0.
- One sub-module instance: the existing `alu2bit` (a, b, s, m, cin, f, cout). It is purely combinational.
- The sequencer holds the FSM, the operand/result shift registers, the carry reg and the index counter. Target size is about 150 lines.

## Test plan
- Logic op:
  - Stimulus: WIDTH=8, a=8'h5A, b=8'h3C, m=1, s=4'b0110, cin=1.
  - Response: `rsp_f`=8'h66, `rsp_zero`=0, `rsp_valid` exactly 4 cycles after the accept edge.
- Add without carry-out:
  - Stimulus: a=8'h0F, b=8'h01, m=0, s=4'b1001, cin=1 (no carry).
  - Response: `rsp_f`=8'h10, `rsp_cout`=1 (no carry-out).
- Add with wrap:
  - Stimulus: a=8'hFF, b=8'h01, m=0, s=4'b1001, cin=1.
  - Response: `rsp_f`=8'h00, `rsp_cout`=0 (carry-out), `rsp_zero`=1. This checks the carry propagating through all 4 slices.
- Backpressure:
  - Stimulus: hold `rsp_ready`=0 for 5 cycles after `rsp_valid`, and keep `req_valid` high with new operands.
  - Response: `rsp_f`/`rsp_cout` stable, `req_ready`=0 throughout, second request accepted only after the response handshake plus 1 IDLE cycle.
- Operand change mid-RUN:
  - Stimulus: change `req_a`/`req_b`/`req_s` during RUN.
  - Response: result matches the values captured at accept.
- Reset mid-RUN:
  - Stimulus: assert `rst_n`=0 asynchronously after 2 RUN cycles.
  - Response: outputs return to reset values immediately, no `rsp_valid` pulse, next request completes correctly.
